// File: rtl/prim_sel_pkg.sv
// Shared types and constants for the primitive-select scheduler.
// Sized for the 19-way primitive-select decoder.
package prim_sel_pkg;

    localparam int NREQ   = 19;
    localparam int HOLD_W = 4;
    localparam int PTR_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_e;

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/prim_sel_sched_if.sv
// Request/select bundle between requesters and the scheduler.
// The scheduler takes the slave side.
interface prim_sel_sched_if;
    import prim_sel_pkg::*;

    logic [NREQ-1:0]   req;
    logic [HOLD_W-1:0] hold_cycles;
    logic              abort;
    logic [NREQ-1:0]   sel_prim;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output req, hold_cycles, abort,
        input  sel_prim, gnt, busy, done, aborted
    );

    modport slave (
        input  req, hold_cycles, abort,
        output sel_prim, gnt, busy, done, aborted
    );

endinterface

// File: rtl/rr_pick.sv
// Find-first-set from a rotating start pointer.
// Two copies of req side by side make the wrapped scan a plain scan.
module rr_pick
    import prim_sel_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    localparam logic [PTR_W:0] N6 = (PTR_W+1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] cand;
    logic [PTR_W:0]    pos;

    // mask off bits below ptr, then take the lowest remaining set bit
    always_comb begin
        dbl   = {req, req};
        cand  = '0;
        pos   = '0;
        valid = |req;
        for (int i = 0; i < 2*NREQ; i++) begin
            cand[i] = dbl[i] & ((PTR_W+1)'(i) >= {1'b0, ptr});
        end
        for (int i = 2*NREQ-1; i >= 0; i--) begin
            if (cand[i]) pos = (PTR_W+1)'(i);
        end
        idx = PTR_W'((pos >= N6) ? pos - N6 : pos);
    end

endmodule

// File: rtl/prim_sel_sched.sv
// Round-robin scheduler sharing the primitive-select decoder.
// One-hot select per grant, followed by a one-cycle all-zero gap.
module prim_sel_sched
    import prim_sel_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    prim_sel_sched_if.slave bus
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ-1);

    state_e            state;
    state_e            state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  winner;
    logic [HOLD_W-1:0] cnt;
    logic [NREQ-1:0]   sel;
    logic              aborted_q;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic              last;
    logic              busy;
    logic              done;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign last = (cnt == HOLD_W'(1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: arbitrate in IDLE, leave HOLD on abort or last count
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_valid) state_nxt = HOLD;
            HOLD:    if (bus.abort || last) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // status outputs; abort suppresses the completion pulse
    always_comb begin
        busy = (state != IDLE);
        done = (state == HOLD) && last && !bus.abort;
    end

    // grant capture, hold countdown and pointer advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            winner    <= '0;
            cnt       <= '0;
            sel       <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel    <= onehot(pick_idx);
                        winner <= pick_idx;
                        cnt    <= (bus.hold_cycles == '0) ?
                                  HOLD_W'(1) : bus.hold_cycles;
                    end
                end
                HOLD: begin
                    if (bus.abort || last) begin
                        sel       <= '0;
                        cnt       <= '0;
                        ptr       <= (winner == LAST_IDX) ?
                                     '0 : winner + 1'b1;
                        aborted_q <= bus.abort;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sel_prim = sel;
    assign bus.gnt      = sel;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.aborted  = aborted_q;

    a_sel_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(sel));

    a_done_xor_abort: assert property (
        @(posedge clk) disable iff (rst) !(done && aborted_q));

endmodule

// File: tb/tb_prim_sel_sched.sv
// Randomized and directed bench for prim_sel_sched.
// Compares the DUT each cycle against a transaction-level model.
module tb_prim_sel_sched;
    import prim_sel_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prim_sel_sched_if bus();

    prim_sel_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // model: phase 0 idle, 1 holding, 2 gap
    int              m_phase = 0;
    int              m_left  = 0;
    int              m_win   = 0;
    int              m_ptr   = 0;
    logic            m_aborted = 1'b0;
    logic [NREQ-1:0] m_sel = '0;
    int              g_win[$];
    int              g_time[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_left    = 0;
        m_win     = 0;
        m_ptr     = 0;
        m_aborted = 1'b0;
        m_sel     = '0;
    endtask

    // advance the model across one clock edge using pre-edge inputs
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        m_aborted = 1'b0;
        case (m_phase)
            0: begin
                if (bus.req != '0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (bus.req[(m_ptr + k) % NREQ]) begin
                            m_win = (m_ptr + k) % NREQ;
                            break;
                        end
                    end
                    m_left = (bus.hold_cycles == 0) ? 1 : int'(bus.hold_cycles);
                    m_sel = '0;
                    m_sel[m_win] = 1'b1;
                    m_phase = 1;
                    g_win.push_back(m_win);
                    g_time.push_back(cycle);
                end
            end
            1: begin
                if (bus.abort || m_left == 1) begin
                    m_aborted = bus.abort;
                    m_sel = '0;
                    m_ptr = (m_win + 1) % NREQ;
                    m_phase = 2;
                end else begin
                    m_left--;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        logic exp_done;
        exp_done = (m_phase == 1) && (m_left == 1) && !bus.abort;
        chk("sel_prim", 32'(bus.sel_prim), 32'(m_sel));
        chk("gnt", 32'(bus.gnt), 32'(m_sel));
        chk("busy", 32'(bus.busy), 32'(m_phase != 0));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("aborted", 32'(bus.aborted), 32'(m_aborted));
        chk("onehot0", 32'($onehot0(bus.sel_prim)), 32'd1);
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic [HOLD_W-1:0] h,
                        input logic a);
        @(posedge clk);
        cycle++;
        model_step();
        #2;
        bus.req = r;
        bus.hold_cycles = h;
        bus.abort = a;
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        step('0, '0, 1'b0);
        while (m_phase != 0 && n < 40) begin
            step('0, '0, 1'b0);
            n++;
        end
        if (m_phase != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: phase %0d after %0d cycles", m_phase, n);
        end
    endtask

    initial begin
        logic [NREQ-1:0] r;
        bus.req = '0;
        bus.hold_cycles = '0;
        bus.abort = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // idle with no requests
        repeat (10) begin
            step('0, '0, 1'b0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        // bit 3, hold 3
        step(19'h00008, 4'd3, 1'b0);
        step('0, 4'd3, 1'b0);
        chk("t2_sel_h1", 32'(bus.sel_prim), 32'h8);
        chk("t2_done_h1", 32'(bus.done), 32'd0);
        step('0, 4'd0, 1'b0);
        chk("t2_sel_h2", 32'(bus.sel_prim), 32'h8);
        step('0, 4'd0, 1'b0);
        chk("t2_sel_h3", 32'(bus.sel_prim), 32'h8);
        chk("t2_done_h3", 32'(bus.done), 32'd1);
        step('0, 4'd0, 1'b0);
        chk("t2_gap_sel", 32'(bus.sel_prim), 32'd0);
        chk("t2_gap_busy", 32'(bus.busy), 32'd1);
        step('0, 4'd0, 1'b0);
        chk("t2_idle_busy", 32'(bus.busy), 32'd0);
        step(19'h00024, 4'd2, 1'b0);
        step('0, 4'd0, 1'b0);
        chk("t2_ptr4", 32'(bus.sel_prim), 32'h20);

        // abort in 3rd hold cycle of an 8-cycle grant to bit 7
        wait_idle();
        step(19'h00080, 4'd8, 1'b0);
        step('0, 4'd8, 1'b0);
        chk("ab_sel", 32'(bus.sel_prim), 32'h80);
        step('0, 4'd0, 1'b0);
        step('0, 4'd0, 1'b1);
        chk("ab_busy_h3", 32'(bus.busy), 32'd1);
        step('0, 4'd0, 1'b0);
        chk("ab_sel0", 32'(bus.sel_prim), 32'd0);
        chk("ab_pulse", 32'(bus.aborted), 32'd1);
        chk("ab_nodone", 32'(bus.done), 32'd0);
        step('0, 4'd0, 1'b0);
        chk("ab_pulse_end", 32'(bus.aborted), 32'd0);
        wait_idle();
        step(19'h00180, 4'd1, 1'b0);
        step('0, 4'd0, 1'b0);
        chk("ab_ptr8", 32'(bus.sel_prim), 32'h100);

        // abort on the last hold cycle beats completion
        wait_idle();
        step(19'h00200, 4'd2, 1'b0);
        step('0, 4'd0, 1'b0);
        step('0, 4'd0, 1'b1);
        chk("ablast_done", 32'(bus.done), 32'd0);
        step('0, 4'd0, 1'b0);
        chk("ablast_pulse", 32'(bus.aborted), 32'd1);

        // wrap scan from ptr 5
        wait_idle();
        step(19'h00010, 4'd0, 1'b0);
        wait_idle();
        step(19'h00011, 4'd0, 1'b0);
        step('0, 4'd0, 1'b0);
        chk("wrap_sel", 32'(bus.sel_prim), 32'h1);
        wait_idle();
        step(19'h00003, 4'd0, 1'b0);
        step('0, 4'd0, 1'b0);
        chk("wrap_ptr1", 32'(bus.sel_prim), 32'h2);

        // async reset mid-hold
        wait_idle();
        step(19'h01000, 4'd5, 1'b0);
        step('0, 4'd0, 1'b0);
        step('0, 4'd0, 1'b0);
        chk("rst_pre", 32'(bus.sel_prim), 32'h1000);
        #1 rst = 1'b1;
        #1;
        chk("rst_sel", 32'(bus.sel_prim), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // all requesters, hold 0: strict rotation from ptr 0
        g_win.delete();
        g_time.delete();
        repeat (62) step({NREQ{1'b1}}, 4'd0, 1'b0);
        if (g_win.size() < 20) begin
            vectors++;
            miscompares++;
            $display("FAIL rot_count: got %0d grants need 20", g_win.size());
        end else begin
            for (int i = 0; i < 20; i++)
                chk("rot_win", 32'(g_win[i]), 32'(i % NREQ));
            for (int i = 1; i < 20; i++)
                chk("rot_period", 32'(g_time[i] - g_time[i-1]), 32'd3);
        end

        // randomized traffic
        repeat (3000) begin
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = NREQ'(1) << $urandom_range(0, NREQ-1);
                default: r = NREQ'($urandom);
            endcase
            step(r, HOLD_W'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
